// File: rtl/cfo_est_stream.sv
// Streaming OFDM carrier-frequency-offset estimator: cyclic-prefix correlation followed by an
// iterative vectoring CORDIC. Define CFO_AVG_EN to average the correlation over nsym symbols.
module cfo_est_stream #(
   parameter int DW     = 12,
   parameter int MAX_NG = 512,
   parameter int AW     = 40,
   parameter int OW     = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [11:0]          ng,
   input  logic [11:0]          nfft,
   input  logic [3:0]           nsym,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic signed [OW-1:0] cfo
);
   localparam int PW  = 2*DW+1;
   localparam int BAW = (MAX_NG > 1) ? $clog2(MAX_NG) : 1;
   localparam int NW  = OW+2;
   localparam int GB  = 4;
   localparam int CW  = NW+3+GB;
   localparam int RCW = $clog2(OW+3)+1;
   localparam logic signed [AW:0]   SMAX = (AW+1)'((64'd1 << (AW-1)) - 64'd1);
   localparam logic signed [AW:0]   SMIN = -SMAX;
   localparam logic signed [AW-1:0] NMAX = AW'((64'd1 << (NW-1)) - 64'd1);
   localparam logic signed [AW-1:0] NMIN = -NMAX - AW'(1);
   localparam logic [12:0]          MAX_NG_V = 13'(MAX_NG);

   typedef enum logic [1:0] {IDLE, RUN, ROT, OUT} state_t;

   // Sample handshake: a sample moves on a rising edge where in_valid and in_ready are both 1;
   // in_ready is high for the whole of RUN and never depends on in_valid.
   state_t                state_q, state_d;
   logic [11:0]           ng_q, ng_d, nfft_q, nfft_d;
   logic [3:0]            nsym_q, nsym_d, sym_q, sym_d, nsym_cfg;
   logic [12:0]           k_q, k_d;
   logic [RCW-1:0]        rot_q, rot_d, it;
   logic signed [PW-1:0]  prod_re_q, prod_re_d, prod_im_q, prod_im_d, pr_re, pr_im;
   logic                  prod_vld_q, prod_vld_d, zero_q, zero_d, err_q, err_d;
   logic signed [AW-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic signed [CW-1:0]  x_q, x_d, y_q, y_d, x_ld, y_ld;
   logic [31:0]           z_q, z_d, z_rnd;
   logic signed [OW-1:0]  cfo_q, cfo_d;
   logic [2*DW-1:0]       cp_mem [MAX_NG];
   logic [2*DW-1:0]       cp_rd;
   logic signed [DW-1:0]  b_re, b_im;
   logic signed [2*DW-1:0] m_rr, m_ii, m_ir, m_ri;
   logic signed [NW-1:0]  nrm_re, nrm_im;
   logic [12:0]           sym_len;
   logic                  accept, cfg_bad;
   int                    sh;

`ifdef CFO_AVG_EN
   assign nsym_cfg = nsym;
`else
   logic unused_nsym;
   assign unused_nsym = ^nsym;
   assign nsym_cfg    = 4'd1;
`endif

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN) || (state_q == ROT);
   assign done     = (state_q == OUT);
   assign err      = err_q;
   assign cfo      = cfo_q;
   assign accept   = in_valid && in_ready;
   assign sym_len  = {1'b0, nfft_q} + {1'b0, ng_q};
   assign cfg_bad  = (ng == 12'd0) || (ng > nfft) || ({1'b0, ng} > MAX_NG_V) || (nsym_cfg == 4'd0);
   assign it       = rot_q - RCW'(2);
   assign z_rnd    = z_q + (32'd1 << (31-OW));

   function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                    input logic signed [PW-1:0] b);
      logic signed [AW:0] s;
      s = (AW+1)'(a) + (AW+1)'(b);
      if (s > SMAX)      sat_add = SMAX[AW-1:0];
      else if (s < SMIN) sat_add = SMIN[AW-1:0];
      else               sat_add = s[AW-1:0];
   endfunction

   function automatic logic fits_nw(input logic signed [AW-1:0] v);
      fits_nw = (v >= NMIN) && (v <= NMAX);
   endfunction

   // atan(2^-i) with a full turn equal to 2^32, so the phase register wraps exactly at +-pi.
   function automatic logic [31:0] atan_lut(input logic [RCW-1:0] i);
      case (i)
         0:       atan_lut = 32'h2000_0000;
         1:       atan_lut = 32'h12E4_051E;
         2:       atan_lut = 32'h09FB_385B;
         3:       atan_lut = 32'h0511_11D4;
         4:       atan_lut = 32'h028B_0D43;
         5:       atan_lut = 32'h0145_D7E1;
         6:       atan_lut = 32'h00A2_F61E;
         7:       atan_lut = 32'h0051_7C55;
         8:       atan_lut = 32'h0028_BE53;
         9:       atan_lut = 32'h0014_5F2F;
         10:      atan_lut = 32'h000A_2F98;
         11:      atan_lut = 32'h0005_17CC;
         12:      atan_lut = 32'h0002_8BE6;
         13:      atan_lut = 32'h0001_45F3;
         14:      atan_lut = 32'h0000_A2FA;
         15:      atan_lut = 32'h0000_517D;
         default: atan_lut = 32'(64'd683565276 >> i);
      endcase
   endfunction

   // Cyclic-prefix store; holds no state that matters between runs, so it is not reset.
   always_ff @(posedge clk) begin
      if (accept && (k_q < {1'b0, ng_q})) cp_mem[BAW'(k_q)] <= {in_re, in_im};
   end

   always_comb begin
      cp_rd = cp_mem[BAW'(k_q - {1'b0, nfft_q})];
      b_re  = cp_rd[2*DW-1:DW];
      b_im  = cp_rd[DW-1:0];
      m_rr  = in_re * b_re;
      m_ii  = in_im * b_im;
      m_ir  = in_im * b_re;
      m_ri  = in_re * b_im;
      pr_re = PW'(m_rr) + PW'(m_ii);
      pr_im = PW'(m_ir) - PW'(m_ri);
   end

   // Smallest common shift that brings both accumulators into NW signed bits.
   always_comb begin
      sh = 0;
      for (int s = AW-1; s >= 0; s--) begin
         if (fits_nw(acc_re_q >>> s) && fits_nw(acc_im_q >>> s)) sh = s;
      end
      nrm_re = NW'(acc_re_q >>> sh);
      nrm_im = NW'(acc_im_q >>> sh);
      x_ld   = CW'(nrm_re) <<< GB;
      y_ld   = CW'(nrm_im) <<< GB;
   end

   always_comb begin
      state_d = state_q;  ng_d = ng_q;  nfft_d = nfft_q;  nsym_d = nsym_q;
      k_d = k_q;  sym_d = sym_q;  rot_d = rot_q;
      prod_re_d = prod_re_q;  prod_im_d = prod_im_q;  prod_vld_d = 1'b0;
      acc_re_d = acc_re_q;  acc_im_d = acc_im_q;
      x_d = x_q;  y_d = y_q;  z_d = z_q;  zero_d = zero_q;
      err_d = err_q;  cfo_d = cfo_q;

      if (prod_vld_q) begin
         acc_re_d = sat_add(acc_re_q, prod_re_q);
         acc_im_d = sat_add(acc_im_q, prod_im_q);
      end
      if (accept && (k_q >= {1'b0, nfft_q})) begin
         prod_re_d  = pr_re;
         prod_im_d  = pr_im;
         prod_vld_d = 1'b1;
      end

      case (state_q)
         IDLE: if (go) begin
            ng_d = ng;  nfft_d = nfft;  nsym_d = nsym_cfg;
            k_d = '0;  sym_d = '0;  rot_d = '0;
            acc_re_d = '0;  acc_im_d = '0;
            if (cfg_bad) begin
               state_d = OUT;
               err_d   = 1'b1;
               cfo_d   = '0;
            end else begin
               state_d = RUN;
            end
         end
         RUN: if (accept) begin
            if (k_q == sym_len - 13'd1) begin
               k_d = '0;
               if (sym_q == nsym_q - 4'd1) begin
                  state_d = ROT;
                  rot_d   = '0;
               end else begin
                  sym_d = sym_q + 4'd1;
               end
            end else begin
               k_d = k_q + 13'd1;
            end
         end
         ROT: begin
            rot_d = rot_q + RCW'(1);
            if (rot_q == RCW'(1)) begin
               // Left half-plane vectors are flipped by pi so the CORDIC only sees |angle| < pi/2.
               zero_d = (acc_re_q == '0) && (acc_im_q == '0);
               if (x_ld[CW-1]) begin
                  x_d = -x_ld;  y_d = -y_ld;  z_d = 32'h8000_0000;
               end else begin
                  x_d = x_ld;   y_d = y_ld;   z_d = '0;
               end
            end else if ((rot_q >= RCW'(2)) && (rot_q < RCW'(OW+2))) begin
               if (!y_q[CW-1]) begin
                  x_d = x_q + (y_q >>> it);
                  y_d = y_q - (x_q >>> it);
                  z_d = z_q + atan_lut(it);
               end else begin
                  x_d = x_q - (y_q >>> it);
                  y_d = y_q + (x_q >>> it);
                  z_d = z_q - atan_lut(it);
               end
            end else if (rot_q == RCW'(OW+2)) begin
               state_d = OUT;
               err_d   = 1'b0;
               cfo_d   = zero_q ? '0 : z_rnd[31 -: OW];
            end
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;  ng_q <= '0;  nfft_q <= '0;  nsym_q <= '0;
         k_q <= '0;  sym_q <= '0;  rot_q <= '0;
         prod_re_q <= '0;  prod_im_q <= '0;  prod_vld_q <= 1'b0;
         acc_re_q <= '0;  acc_im_q <= '0;
         x_q <= '0;  y_q <= '0;  z_q <= '0;  zero_q <= 1'b0;
         err_q <= 1'b0;  cfo_q <= '0;
      end else begin
         state_q <= state_d;  ng_q <= ng_d;  nfft_q <= nfft_d;  nsym_q <= nsym_d;
         k_q <= k_d;  sym_q <= sym_d;  rot_q <= rot_d;
         prod_re_q <= prod_re_d;  prod_im_q <= prod_im_d;  prod_vld_q <= prod_vld_d;
         acc_re_q <= acc_re_d;  acc_im_q <= acc_im_d;
         x_q <= x_d;  y_q <= y_d;  z_q <= z_d;  zero_q <= zero_d;
         err_q <= err_d;  cfo_q <= cfo_d;
      end
   end
endmodule

// File: tb/tb_cfo_est_stream.sv
// Bench for cfo_est_stream: drives cyclic-prefix tones with known offset and scoreboards the
// cfo/err/sample-count/latency of every done strobe against expectations queued at go time.
module tb_cfo_est_stream;
   localparam int DW  = 12;
   localparam int OW  = 12;
   localparam int LAT = OW + 3;
`ifdef CFO_AVG_EN
   localparam int AVG_N = 320;
`else
   localparam int AVG_N = 80;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 go = 1'b0;
   logic [11:0]          ng = '0;
   logic [11:0]          nfft = '0;
   logic [3:0]           nsym = '0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_re = '0;
   logic signed [DW-1:0] in_im = '0;
   logic                 in_ready, busy, done, err;
   logic signed [OW-1:0] cfo;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int last_acc_edge = 0;
   int done_cnt = 0;
   bit rdy_seen = 1'b0;

   logic signed [OW-1:0] exp_q[$];
   int                   exp_tol_q[$];
   logic                 exp_err_q[$];
   int                   exp_n_q[$];

   cfo_est_stream dut (
      .clk(clk), .reset(reset), .go(go), .ng(ng), .nfft(nfft), .nsym(nsym),
      .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
      .in_ready(in_ready), .busy(busy), .done(done), .err(err), .cfo(cfo)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      int d;
      n_checks++;
      d = (obs > exp) ? obs - exp : exp - obs;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic int rnd_int(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      int o, e, t, n;
      logic ee;
      if (in_ready) rdy_seen = 1'b1;
      if (in_valid && in_ready) begin
         n_acc++;
         last_acc_edge = cyc + 1;
      end
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0, 0);
         end else begin
            e  = int'(exp_q.pop_front());
            t  = exp_tol_q.pop_front();
            ee = exp_err_q.pop_front();
            n  = exp_n_q.pop_front();
            o  = int'(cfo);
            if (o - e > 2048) o -= 4096;
            else if (e - o > 2048) o += 4096;
            check("cfo", o, e, t);
            check("err", int'(err), int'(ee), 0);
            check("n_samples", n_acc, n, 0);
            if (n > 0) check("latency", cyc - last_acc_edge, LAT, 0);
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, int'(in_ready), 0, 0);
      check({tag, "_busy"}, int'(busy), 0, 0);
      check({tag, "_done"}, int'(done), 0, 0);
      check({tag, "_err"}, int'(err), 0, 0);
      check({tag, "_cfo"}, int'(cfo), 0, 0);
   endtask

   // driver: start a run, stream tone samples until the DUT stops accepting, wait for done
   task automatic run_case(input real eps, input real amp, input int ng_i, input int nfft_i,
                           input int nsym_i, input bit rnd_valid, input bit hold_go,
                           input int exp_c, input int tol, input bit exp_e, input int exp_n,
                           input int abort_after);
      int  n, guard, d0;
      bit  take;
      real ph;
      if (abort_after < 0) begin
         exp_q.push_back(OW'(exp_c));
         exp_tol_q.push_back(tol);
         exp_err_q.push_back(exp_e);
         exp_n_q.push_back(exp_n);
      end
      n_acc = 0;
      rdy_seen = 1'b0;
      d0 = done_cnt;
      @(posedge clk); #1;
      ng = 12'(ng_i);  nfft = 12'(nfft_i);  nsym = 4'(nsym_i);  go = 1'b1;
      @(posedge clk); #1;
      go = hold_go;
      ng = 12'hfff;  nfft = 12'd1;  nsym = 4'd0;
      n = 0;
      guard = 0;
      while (in_ready && guard < 4000 && (abort_after < 0 || n < abort_after)) begin
         in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         ph = 6.283185307179586 * eps * real'(n) / real'(nfft_i);
         in_re = DW'(rnd_int(amp * $cos(ph)));
         in_im = DW'(rnd_int(amp * $sin(ph)));
         take = in_valid;
         @(posedge clk); #1;
         if (take) n++;
         guard++;
      end
      in_valid = 1'b0;
      if (abort_after >= 0) return;
      guard = 0;
      while (!done && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      go = 1'b0;
      @(posedge clk); #1;
      check("done_seen", done_cnt - d0, 1, 0);
      if (exp_n == 0) check("rdy_never", int'(rdy_seen), 0, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;

      run_case( 0.125, 1000.0, 16, 64, 1, 1'b0, 1'b0,   512, 2, 1'b0, 80, -1);
      run_case(-0.25,  1000.0, 16, 64, 1, 1'b0, 1'b0, -1024, 2, 1'b0, 80, -1);

      // abort mid-run with a nonzero result still on cfo
      run_case( 0.125, 1000.0, 16, 64, 1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 30);
      reset = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      run_case( 0.125, 1000.0, 16, 64, 1, 1'b0, 1'b0,   512, 2, 1'b0, 80, -1);

      run_case( 0.0,   1000.0, 16, 64, 4, 1'b0, 1'b0,     0, 1, 1'b0, AVG_N, -1);
      run_case( 0.125, 1000.0,  0, 64, 1, 1'b0, 1'b0,     0, 0, 1'b1, 0, -1);
      run_case( 0.125, 1000.0, 80, 64, 1, 1'b0, 1'b0,     0, 0, 1'b1, 0, -1);
      run_case( 0.125,    0.0, 16, 64, 1, 1'b0, 1'b0,     0, 0, 1'b0, 80, -1);
      run_case( 0.5,   1000.0, 16, 64, 1, 1'b0, 1'b0, -2048, 2, 1'b0, 80, -1);
      run_case( 0.125, 1000.0, 16, 64, 1, 1'b1, 1'b1,   512, 2, 1'b0, 80, -1);
      run_case(-0.25,  1000.0,  8, 32, 1, 1'b1, 1'b0, -1024, 2, 1'b0, 40, -1);

      check("sb_drained", exp_q.size(), 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
